// File: rtl/lag_pkg.sv
// Shared definitions for the input-lag measurement controller.
// The state encoding is fixed so status readback stays stable across revisions.
package lag_pkg;

    localparam int LAG_W_DEF = 17;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        DARK   = 3'd1,
        ARM    = 3'd2,
        FLASH  = 3'd3,
        RESULT = 3'd4,
        COOL   = 3'd5
    } lag_state_t;

endpackage

// File: rtl/sensor_debounce.sv
// Photo sensor conditioning: 2-FF synchronizer followed by a stability filter.
// lit is active-high (light seen), while the raw sensor is active-low.
module sensor_debounce #(
    parameter int DEBOUNCE_CYC = 16
) (
    input  logic clock,
    input  logic reset,
    input  logic sensor_n,
    output logic lit
);

    localparam int CNT_W = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;

    logic             sync_1;
    logic             sync_2;
    logic             light;
    logic [CNT_W-1:0] stable_cnt;

    assign light = ~sync_2;

    // The synchronizer resets to "dark" so the filter starts out agreeing with lit.
    always_ff @(posedge clock) begin
        if (!reset) begin
            sync_1     <= 1'b1;
            sync_2     <= 1'b1;
            stable_cnt <= '0;
            lit        <= 1'b0;
        end else begin
            sync_1 <= sensor_n;
            sync_2 <= sync_1;
            if (light == lit) begin
                stable_cnt <= '0;
            end else if (stable_cnt == CNT_W'(DEBOUNCE_CYC - 1)) begin
                lit        <= light;
                stable_cnt <= '0;
            end else begin
                stable_cnt <= stable_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/lag_measure_ctrl.sv
// Input-lag measurement sequencer: flashes a patch at a frame start, times the
// photo sensor response in microseconds and keeps a block average of the results.
module lag_measure_ctrl
    import lag_pkg::*;
#(
    parameter int LAG_W        = LAG_W_DEF,
    parameter int MAX_US       = 100000,
    parameter int DEBOUNCE_CYC = 16,
    parameter int SETTLE_FRM   = 4,
    parameter int FLASH_FRM    = 8,
    parameter int COOL_FRM     = 16,
    parameter int AVG_LOG2     = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    input  logic [7:0]       clks_per_us,
    input  logic             frame_start,
    input  logic             sensor_n,
    output logic             flash_on,
    output logic             busy,
    output logic             sample_valid,
    output logic [LAG_W-1:0] lag_us,
    output logic             timeout,
    output logic             avg_valid,
    output logic [LAG_W-1:0] avg_us
);

    localparam int FRM_W = 8;
    localparam int SUM_W = LAG_W + AVG_LOG2;

    lag_state_t          state;
    logic                lit;
    logic [7:0]          presc;
    logic [7:0]          presc_limit;
    logic                us_tick;
    logic [LAG_W-1:0]    us_cnt;
    logic [FRM_W-1:0]    frm_cnt;
    logic [SUM_W-1:0]    sum;
    logic [SUM_W-1:0]    sum_next;
    logic [AVG_LOG2-1:0] avg_cnt;

    sensor_debounce #(
        .DEBOUNCE_CYC(DEBOUNCE_CYC)
    ) u_debounce (
        .clock    (clock),
        .reset    (reset),
        .sensor_n (sensor_n),
        .lit      (lit)
    );

    // A >= compare lets a lowered clks_per_us take effect on the very next clock.
    assign presc_limit = (clks_per_us == 8'd0) ? 8'd1 : clks_per_us;
    assign us_tick     = (presc >= presc_limit - 8'd1);
    assign sum_next    = sum + SUM_W'(lag_us);

    always_ff @(posedge clock) begin
        if (!reset) begin
            state        <= IDLE;
            presc        <= '0;
            us_cnt       <= '0;
            frm_cnt      <= '0;
            flash_on     <= 1'b0;
            busy         <= 1'b0;
            sample_valid <= 1'b0;
            lag_us       <= '0;
            timeout      <= 1'b0;
        end else begin
            sample_valid <= 1'b0;
            presc        <= us_tick ? 8'd0 : presc + 8'd1;
            if (!enable) begin
                state    <= IDLE;
                flash_on <= 1'b0;
                busy     <= 1'b0;
                us_cnt   <= '0;
                frm_cnt  <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        state   <= DARK;
                        busy    <= 1'b1;
                        frm_cnt <= '0;
                    end
                    DARK: begin
                        if (lit) begin
                            frm_cnt <= '0;
                        end else if (frame_start) begin
                            if (frm_cnt == FRM_W'(SETTLE_FRM - 1)) begin
                                state   <= ARM;
                                frm_cnt <= '0;
                            end else begin
                                frm_cnt <= frm_cnt + 1'b1;
                            end
                        end
                    end
                    ARM: begin
                        if (frame_start) begin
                            state    <= FLASH;
                            flash_on <= 1'b1;
                            us_cnt   <= '0;
                            presc    <= '0;
                            frm_cnt  <= '0;
                        end
                    end
                    // A light detection in the timeout cycle still counts as a real sample.
                    FLASH: begin
                        if (frame_start && frm_cnt < FRM_W'(FLASH_FRM)) begin
                            frm_cnt <= frm_cnt + 1'b1;
                        end
                        if (lit) begin
                            state        <= RESULT;
                            lag_us       <= us_cnt;
                            timeout      <= 1'b0;
                            sample_valid <= 1'b1;
                        end else if (us_cnt == LAG_W'(MAX_US)) begin
                            state        <= RESULT;
                            lag_us       <= LAG_W'(MAX_US);
                            timeout      <= 1'b1;
                            sample_valid <= 1'b1;
                        end else if (us_tick) begin
                            us_cnt <= us_cnt + 1'b1;
                        end
                    end
                    RESULT: begin
                        if (frm_cnt >= FRM_W'(FLASH_FRM)) begin
                            state    <= COOL;
                            flash_on <= 1'b0;
                            frm_cnt  <= '0;
                        end else if (frame_start) begin
                            frm_cnt <= frm_cnt + 1'b1;
                        end
                    end
                    COOL: begin
                        if (frame_start) begin
                            if (frm_cnt == FRM_W'(COOL_FRM - 1)) begin
                                state   <= DARK;
                                frm_cnt <= '0;
                            end else begin
                                frm_cnt <= frm_cnt + 1'b1;
                            end
                        end
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

    // Averager consumes the published sample, so avg_valid trails sample_valid by one clock.
    always_ff @(posedge clock) begin
        if (!reset) begin
            sum       <= '0;
            avg_cnt   <= '0;
            avg_us    <= '0;
            avg_valid <= 1'b0;
        end else begin
            avg_valid <= 1'b0;
            if (sample_valid && !timeout) begin
                if (avg_cnt == '1) begin
                    avg_us    <= sum_next[SUM_W-1:AVG_LOG2];
                    avg_valid <= 1'b1;
                    sum       <= '0;
                    avg_cnt   <= '0;
                end else begin
                    sum     <= sum_next;
                    avg_cnt <= avg_cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_lag_measure_ctrl.sv
// Bench for lag_measure_ctrl: directed measurement cycles feed a scoreboard that a
// negedge monitor drains; a second instance with a short timeout covers the timeout paths.
module tb_lag_measure_ctrl;

    localparam int LAG_W   = 17;
    localparam int FRAME_P = 40;

    typedef struct {
        int lag;
        int to;
    } sample_t;

    logic             clock;
    logic             reset;
    logic             enable;
    logic             enable_to;
    logic [7:0]       clks_per_us;
    logic             frame_start;
    logic             sensor_n;

    logic             flash_on, busy, sample_valid, timeout, avg_valid;
    logic [LAG_W-1:0] lag_us, avg_us;
    logic             flash_on_to, busy_to, sample_valid_to, timeout_to, avg_valid_to;
    logic [LAG_W-1:0] lag_us_to, avg_us_to;

    sample_t exp_main[$];
    sample_t exp_to[$];
    int      exp_avg[$];

    int tests = 0;
    int fails = 0;
    int cycle = 0;
    int last_sv_cycle = 0;
    int avg_pulses_to = 0;

    lag_measure_ctrl dut (
        .clock        (clock),
        .reset        (reset),
        .enable       (enable),
        .clks_per_us  (clks_per_us),
        .frame_start  (frame_start),
        .sensor_n     (sensor_n),
        .flash_on     (flash_on),
        .busy         (busy),
        .sample_valid (sample_valid),
        .lag_us       (lag_us),
        .timeout      (timeout),
        .avg_valid    (avg_valid),
        .avg_us       (avg_us)
    );

    lag_measure_ctrl #(
        .MAX_US(1000)
    ) dut_to (
        .clock        (clock),
        .reset        (reset),
        .enable       (enable_to),
        .clks_per_us  (clks_per_us),
        .frame_start  (frame_start),
        .sensor_n     (sensor_n),
        .flash_on     (flash_on_to),
        .busy         (busy_to),
        .sample_valid (sample_valid_to),
        .lag_us       (lag_us_to),
        .timeout      (timeout_to),
        .avg_valid    (avg_valid_to),
        .avg_us       (avg_us_to)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        frame_start = 1'b0;
        for (int f = 0; ; f = (f == FRAME_P - 1) ? 0 : f + 1) begin
            @(posedge clock);
            #1;
            frame_start = (f == 0);
        end
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        tests++;
        if (actual != expected) begin
            fails++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic checkReset(input string tag);
        checkOutput({tag, "_flash_on"}, flash_on, 0);
        checkOutput({tag, "_busy"}, busy, 0);
        checkOutput({tag, "_sample_valid"}, sample_valid, 0);
        checkOutput({tag, "_lag_us"}, lag_us, 0);
        checkOutput({tag, "_timeout"}, timeout, 0);
        checkOutput({tag, "_avg_valid"}, avg_valid, 0);
        checkOutput({tag, "_avg_us"}, avg_us, 0);
    endtask

    function automatic bit dutFlash(input bit use_to);
        return use_to ? flash_on_to : flash_on;
    endfunction

    function automatic bit dutSample(input bit use_to);
        return use_to ? sample_valid_to : sample_valid;
    endfunction

    // Waits for a fresh rising flash_on; returns at the negedge where it is first seen.
    task automatic waitFlash(input bit use_to);
        int n = 0;
        while (dutFlash(use_to) && n < 4000) begin
            @(negedge clock);
            n++;
        end
        while (!dutFlash(use_to) && n < 4000) begin
            @(negedge clock);
            n++;
        end
        checkOutput("wait_flash", dutFlash(use_to), 1);
    endtask

    // One measurement: sensor goes lit lit_n clocks after the flash edge (lit_n < 0 never),
    // with an optional short glitch; the expected sample goes to the scoreboard first.
    task automatic applyStimulus(input bit use_to, input int lit_n, input int glitch_at,
                                 input int glitch_len, input bit hold_lit,
                                 input int exp_lag, input int exp_timeout, input string name);
        sample_t s;
        int      k = 0;
        int      limit;
        bit      done = 1'b0;
        s.lag = exp_lag;
        s.to  = exp_timeout;
        if (use_to) exp_to.push_back(s);
        else        exp_main.push_back(s);
        waitFlash(use_to);
        limit = ((lit_n > 0) ? lit_n : 4000) + 2000;
        while (!done && k < limit) begin
            @(posedge clock);
            #1;
            k++;
            if (k == lit_n || k == glitch_at) sensor_n = 1'b0;
            if (glitch_len > 0 && k == glitch_at + glitch_len) sensor_n = 1'b1;
            done = dutSample(use_to);
        end
        if (!hold_lit) sensor_n = 1'b1;
        checkOutput({name, "_sample_seen"}, done, 1);
    endtask

    // Monitor: pops the scoreboard whenever either instance publishes a result.
    always @(negedge clock) begin
        sample_t s;
        cycle++;
        if (reset) begin
            if (sample_valid) begin
                last_sv_cycle = cycle;
                if (exp_main.size() == 0) begin
                    checkOutput("unexpected_sample_valid", 1, 0);
                end else begin
                    s = exp_main.pop_front();
                    checkOutput("lag_us", lag_us, s.lag);
                    checkOutput("timeout", timeout, s.to);
                end
            end
            if (avg_valid) begin
                if (exp_avg.size() == 0) begin
                    checkOutput("unexpected_avg_valid", 1, 0);
                end else begin
                    checkOutput("avg_us", avg_us, exp_avg.pop_front());
                    checkOutput("avg_latency", cycle - last_sv_cycle, 1);
                end
            end
            if (sample_valid_to) begin
                if (exp_to.size() == 0) begin
                    checkOutput("unexpected_sample_valid_to", 1, 0);
                end else begin
                    s = exp_to.pop_front();
                    checkOutput("to_lag_us", lag_us_to, s.lag);
                    checkOutput("to_timeout", timeout_to, s.to);
                end
            end
            if (avg_valid_to) avg_pulses_to++;
        end
    end

    initial begin
        int flash_cnt;
        reset       = 1'b0;
        enable      = 1'b0;
        enable_to   = 1'b0;
        clks_per_us = 8'd25;
        sensor_n    = 1'b1;
        repeat (5) @(posedge clock);
        @(negedge clock);
        checkReset("por");
        @(posedge clock);
        #1;
        reset  = 1'b1;
        enable = 1'b1;

        $display("[TB] lit 1234 us after flash at 25 clocks/us");
        applyStimulus(0, 1234 * 25, 0, 0, 1'b0, 1234, 0, "t1");

        $display("[TB] 15-clock glitch during flash, then lit held through dark");
        clks_per_us = 8'd4;
        applyStimulus(0, 4 * 200 - 18, 40, 15, 1'b1, 200, 0, "t4_glitch");
        repeat (4) @(negedge clock);
        flash_cnt = 0;
        repeat (1500) begin
            @(negedge clock);
            if (flash_on) flash_cnt++;
        end
        checkOutput("t4_lit_blocks_arm", flash_cnt, 0);
        checkOutput("t4_busy_in_dark", busy, 1);
        sensor_n = 1'b1;

        $display("[TB] enable drops mid-flash");
        waitFlash(0);
        repeat (100) @(posedge clock);
        #1;
        enable = 1'b0;
        @(posedge clock);
        @(negedge clock);
        checkOutput("t5_busy_after_disable", busy, 0);
        checkOutput("t5_flash_after_disable", flash_on, 0);
        repeat (200) @(posedge clock);
        #1;
        enable = 1'b1;

        $display("[TB] reset asserted while in result");
        applyStimulus(0, 4 * 20 - 18, 0, 0, 1'b0, 20, 0, "t5_short");
        repeat (3) @(posedge clock);
        #1;
        checkOutput("t5_flash_in_result", flash_on, 1);
        reset = 1'b0;
        @(posedge clock);
        @(negedge clock);
        checkReset("mid_result");
        @(posedge clock);
        #1;
        reset = 1'b1;

        $display("[TB] block of 16 samples 100..115 us");
        exp_avg.push_back(107);
        for (int lag = 100; lag <= 115; lag++) begin
            applyStimulus(0, 4 * lag - 18, 0, 0, 1'b0, lag, 0, "t3");
        end
        repeat (5) @(negedge clock);

        $display("[TB] short-timeout instance: no light, then light in the timeout cycle");
        enable    = 1'b0;
        enable_to = 1'b1;
        applyStimulus(1, -1, 0, 0, 1'b0, 1000, 1, "t2");
        @(posedge clock);
        @(negedge clock);
        checkOutput("t2_flash_off_in_cool", flash_on_to, 0);
        checkOutput("t2_busy_in_cool", busy_to, 1);
        applyStimulus(1, 4 * 1000 - 18, 0, 0, 1'b0, 1000, 0, "t6");
        repeat (10) @(negedge clock);

        checkOutput("sb_main_drained", exp_main.size(), 0);
        checkOutput("sb_to_drained", exp_to.size(), 0);
        checkOutput("sb_avg_drained", exp_avg.size(), 0);
        checkOutput("t2_no_avg_update", avg_pulses_to, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
